// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control sequencer for the 32-bit ALU datapath.
// It accepts one operation, then steps the datapath through these phases:
// load Y, execute, write Z low (and Z high for MUL/DIV), then done.
// Every strobe is a register, so the strobes have no path from start or opcode.
module alu_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 34
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [3:0]  opcode,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic        RAout,
    output logic        RBout,
    output logic        Yin,
    output logic        Zin,
    output logic [12:0] alu_sel,
    output logic        ZLOout,
    output logic        ZHIout,
    output logic        Rzin,
    output logic        LOin,
    output logic        HIin
);

    // The counter only has to hold the longest execute length minus one.
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES - 1);
    localparam logic [3:0] OP_MUL = 4'd6;
    localparam logic [3:0] OP_DIV = 4'd7;
    localparam logic [3:0] OP_MAX = 4'd12;

    typedef enum logic [2:0] {
        IDLE,
        LDY,
        EXEC,
        WLO,
        WHI,
        DONE,
        ERR
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [3:0]    op;

    logic          multi_word;
    logic [CW-1:0] exec_last;
    logic [12:0]   op_onehot;

    // Derive the properties of the latched operation: its result width, its execute length and its ALU select bit.
    always_comb begin
        multi_word = (op == OP_MUL) || (op == OP_DIV);
        exec_last  = '0;
        if (op == OP_MUL) begin
            exec_last = MUL_LAST;
        end else if (op == OP_DIV) begin
            exec_last = DIV_LAST;
        end
        op_onehot = 13'd1 << op;
    end

    // Update the sequencer state and register, in the same edge, the strobes for the state being entered.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= IDLE;
            count   <= '0;
            op      <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            RAout   <= 1'b0;
            RBout   <= 1'b0;
            Yin     <= 1'b0;
            Zin     <= 1'b0;
            alu_sel <= '0;
            ZLOout  <= 1'b0;
            ZHIout  <= 1'b0;
            Rzin    <= 1'b0;
            LOin    <= 1'b0;
            HIin    <= 1'b0;
        end else begin
            ready   <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            RAout   <= 1'b0;
            RBout   <= 1'b0;
            Yin     <= 1'b0;
            Zin     <= 1'b0;
            alu_sel <= '0;
            ZLOout  <= 1'b0;
            ZHIout  <= 1'b0;
            Rzin    <= 1'b0;
            LOin    <= 1'b0;
            HIin    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (opcode <= OP_MAX)) begin
                        op    <= opcode;
                        state <= LDY;
                        RAout <= 1'b1;
                        Yin   <= 1'b1;
                    end else if (start) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                LDY: begin
                    state   <= EXEC;
                    count   <= exec_last;
                    RBout   <= 1'b1;
                    alu_sel <= op_onehot;
                    Zin     <= (exec_last == '0);
                end
                EXEC: begin
                    if (count == '0) begin
                        state  <= WLO;
                        ZLOout <= 1'b1;
                        Rzin   <= !multi_word;
                        LOin   <= multi_word;
                    end else begin
                        count   <= count - 1'b1;
                        RBout   <= 1'b1;
                        alu_sel <= op_onehot;
                        Zin     <= (count == CW'(1));
                    end
                end
                WLO: begin
                    if (multi_word) begin
                        state  <= WHI;
                        ZHIout <= 1'b1;
                        HIin   <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                WHI: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE, ERR: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench for alu_sequencer.
// A reference model derived from the operation latency table gives the expected strobe vector.
module tb_alu_sequencer;

    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 34;

    logic        clock;
    logic        clear;
    logic        start;
    logic [3:0]  opcode;
    logic        ready, done, err, RAout, RBout, Yin, Zin;
    logic [12:0] alu_sel;
    logic        ZLOout, ZHIout, Rzin, LOin, HIin;
    logic [24:0] obs;

    int checks = 0;
    int fails  = 0;

    alu_sequencer #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clock(clock), .clear(clear), .start(start), .opcode(opcode),
        .ready(ready), .done(done), .err(err), .RAout(RAout), .RBout(RBout),
        .Yin(Yin), .Zin(Zin), .alu_sel(alu_sel), .ZLOout(ZLOout), .ZHIout(ZHIout),
        .Rzin(Rzin), .LOin(LOin), .HIin(HIin)
    );

    assign obs = {ready, done, err, RAout, RBout, Yin, Zin, ZLOout, ZHIout, Rzin, LOin, HIin, alu_sel};

    // Free-running clock with a 10-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Gives the number of cycles after acceptance up to and including the done or err cycle.
    function automatic int op_len(input logic [3:0] op);
        int n;
        if (op > 4'd12) return 1;
        n = (op == 4'd6) ? MUL_CYCLES : (op == 4'd7) ? DIV_CYCLES : 1;
        return ((op == 4'd6) || (op == 4'd7)) ? 4 + n : 3 + n;
    endfunction

    // Gives the expected output vector t cycles after the edge that accepted op.
    function automatic logic [24:0] exp_vec(input logic [3:0] op, input int t);
        logic r, d, e, ra, rb, y, z, zlo, zhi, rz, lo, hi;
        logic [12:0] sel;
        int n;
        bit md;
        {r, d, e, ra, rb, y, z, zlo, zhi, rz, lo, hi} = '0;
        sel = '0;
        md = (op == 4'd6) || (op == 4'd7);
        n = (op == 4'd6) ? MUL_CYCLES : (op == 4'd7) ? DIV_CYCLES : 1;
        if (t > op_len(op)) r = 1'b1;
        else if (op > 4'd12) e = 1'b1;
        else if (t == op_len(op)) d = 1'b1;
        else if (t == 1) begin ra = 1'b1; y = 1'b1; end
        else if (t <= 1 + n) begin rb = 1'b1; sel[op] = 1'b1; z = (t == 1 + n); end
        else if (t == 2 + n) begin zlo = 1'b1; lo = md; rz = !md; end
        else begin zhi = 1'b1; hi = 1'b1; end
        return {r, d, e, ra, rb, y, z, zlo, zhi, rz, lo, hi, sel};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        start = 1'b0;
        opcode = 4'd0;
        tick();
        tick();
        checks++;
        if (obs !== 25'h1000000) begin
            fails++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs, 25'h1000000);
        end
        clear = 1'b1;
        tick();
        checks++;
        if (obs !== 25'h1000000) begin
            fails++;
            $display("[TB] FAIL reset_release_idle: got %h expected %h", obs, 25'h1000000);
        end
    endtask

    // Runs one operation that starts in the current idle cycle and checks every cycle until idle returns.
    task automatic test_single(input logic [3:0] op, input string name);
        start = 1'b1;
        opcode = op;
        tick();
        start = 1'b0;
        opcode = 4'($urandom);
        for (int t = 1; t <= op_len(op) + 1; t++) begin
            checks++;
            if (obs !== exp_vec(op, t)) begin
                fails++;
                $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, t, obs, exp_vec(op, t));
            end
            if (t <= op_len(op)) tick();
        end
    endtask

    task automatic test_add();
        test_single(4'd4, "add");
    endtask

    task automatic test_mul();
        test_single(4'd6, "mul");
    endtask

    task automatic test_div();
        test_single(4'd7, "div");
    endtask

    task automatic test_illegal();
        logic [3:0] bad;
        bad = 4'($urandom_range(13, 15));
        test_single(bad, "illegal");
        start = 1'b1;
        opcode = 4'd4;
        tick();
        for (int t = 1; t <= op_len(4'd4) + 1; t++) begin
            if (t == op_len(4'd4)) start = 1'b0;
            else opcode = 4'($urandom);
            checks++;
            if (obs !== exp_vec(4'd4, t)) begin
                fails++;
                $display("[TB] FAIL start_ignored cycle %0d: got %h expected %h", t, obs, exp_vec(4'd4, t));
            end
            if (t <= op_len(4'd4)) tick();
        end
    endtask

    task automatic test_clear_mid_div();
        start = 1'b1;
        opcode = 4'd7;
        tick();
        start = 1'b0;
        for (int t = 1; t < 12; t++) tick();
        checks++;
        if (obs !== exp_vec(4'd7, 12)) begin
            fails++;
            $display("[TB] FAIL div_before_clear: got %h expected %h", obs, exp_vec(4'd7, 12));
        end
        #2;
        clear = 1'b0;
        #1;
        checks++;
        if (obs !== 25'h1000000) begin
            fails++;
            $display("[TB] FAIL clear_async: got %h expected %h", obs, 25'h1000000);
        end
        tick();
        tick();
        clear = 1'b1;
        tick();
        checks++;
        if (obs !== 25'h1000000) begin
            fails++;
            $display("[TB] FAIL after_clear_idle: got %h expected %h", obs, 25'h1000000);
        end
        test_single(4'd4, "add_after_clear");
    endtask

    task automatic test_back_to_back();
        logic [3:0] op;
        int t0;
        start = 1'b1;
        opcode = 4'd4;
        tick();
        opcode = 4'd5;
        for (int t = 1; t <= op_len(4'd4) + op_len(4'd5) + 2; t++) begin
            op = (t <= op_len(4'd4) + 1) ? 4'd4 : 4'd5;
            t0 = (op == 4'd4) ? t : t - op_len(4'd4) - 1;
            if (t == op_len(4'd4) + 2) start = 1'b0;
            checks++;
            if (obs !== exp_vec(op, t0)) begin
                fails++;
                $display("[TB] FAIL back_to_back cycle %0d: got %h expected %h", t, obs, exp_vec(op, t0));
            end
            checks++;
            if (({3'b0, RAout} + {3'b0, RBout} + {3'b0, ZLOout} + {3'b0, ZHIout}) > 4'd1 || !$onehot0(alu_sel)) begin
                fails++;
                $display("[TB] FAIL b2b_single_driver cycle %0d: got drivers %b sel %h expected at most one each",
                         t, {RAout, RBout, ZLOout, ZHIout}, alu_sel);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        bit hold;
        for (int i = 0; i < 24; i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            op = 4'($urandom);
            hold = 1'($urandom);
            start = 1'b1;
            opcode = op;
            tick();
            start = hold;
            for (int t = 1; t <= op_len(op) + 1; t++) begin
                if (t == op_len(op)) start = 1'b0;
                if (hold) opcode = 4'($urandom);
                checks++;
                if (obs !== exp_vec(op, t)) begin
                    fails++;
                    $display("[TB] FAIL random op %0d cycle %0d: got %h expected %h", op, t, obs, exp_vec(op, t));
                end
                checks++;
                if (({3'b0, RAout} + {3'b0, RBout} + {3'b0, ZLOout} + {3'b0, ZHIout}) > 4'd1 || !$onehot0(alu_sel)) begin
                    fails++;
                    $display("[TB] FAIL random_single_driver op %0d cycle %0d: got drivers %b sel %h",
                             op, t, {RAout, RBout, ZLOout, ZHIout}, alu_sel);
                end
                if (t <= op_len(op)) tick();
            end
        end
    endtask

    // Runs the scenarios in order, then prints the summary.
    initial begin
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_illegal();
        test_clear_mid_div();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
